// File: rtl/ir_pkg.sv
// Shared definitions for the air-conditioner IR command path: scheduler states,
// climate limits and the fixed frame layout.
package ir_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSnap,
      StLaunch,
      StWait,
      StGap
   } sched_state_e;

   localparam int unsigned TEMP_MIN = 16;
   localparam int unsigned TEMP_MAX = 30;
   localparam int unsigned TEMP_RST = 26;
   localparam int unsigned MODE_MAX = 4;

   localparam logic [34:0] FIXED35_DEF = 35'b10000010000100000000010000001010010;
   localparam logic [31:0] FIXED32_DEF = 32'b00001000000001000000000000000110;

   localparam int unsigned D35_MODE_LSB = 32;
   localparam int unsigned D35_PWR_BIT  = 31;
   localparam int unsigned D35_TEMP_LSB = 27;
   localparam int unsigned D32_CHK_LSB  = 0;
   localparam logic [3:0]  CHK_BIAS     = 4'd10;

endpackage

// File: rtl/ir_frame_build.sv
// Combinational frame assembly: overlays power/mode/temperature fields and the
// checksum nibble (data32[3:0]) onto the fixed frame bits.
module ir_frame_build
   import ir_pkg::*;
#(
   parameter logic [34:0] FIXED35 = FIXED35_DEF,
   parameter logic [31:0] FIXED32 = FIXED32_DEF
) (
   input  logic        power,
   input  logic [2:0]  mode,
   input  logic [4:0]  temp,
   output logic [34:0] data35,
   output logic [31:0] data32
);

   logic [3:0] temp_code;
   logic [3:0] chk;

   always_comb begin
      temp_code = 4'(temp - 5'(TEMP_MIN));
      chk       = temp_code + {1'b0, mode} + {3'b000, power} + CHK_BIAS;

      data35 = FIXED35;
      data35[D35_MODE_LSB +: 3] = mode;
      data35[D35_PWR_BIT]       = power;
      data35[D35_TEMP_LSB +: 4] = temp_code;

      data32 = FIXED32;
      data32[D32_CHK_LSB +: 4] = chk;
   end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Tracks the A/C state from the four keys and schedules repeated IR frame
// transmissions with inter-frame gap and transmitter timeout.
module ir_cmd_scheduler
   import ir_pkg::*;
#(
   parameter int unsigned REPEAT      = 2,
   parameter int unsigned GAP_CYC     = 4000000,
   parameter int unsigned TIMEOUT_CYC = 25000000,
   parameter logic [34:0] FIXED35     = FIXED35_DEF,
   parameter logic [31:0] FIXED32     = FIXED32_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_power,
   input  logic        key_mode,
   input  logic        key_up,
   input  logic        key_down,
   input  logic        tx_busy,
   input  logic        tx_done,
   output logic        tx_start,
   output logic [34:0] tx_data35,
   output logic [31:0] tx_data32,
   output logic        sched_busy,
   output logic        pwr_led,
   output logic        err
);

   localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [2:0]       REP_INIT = 3'(REPEAT);

   sched_state_e state_q, state_d;
   logic [3:0]   keys_q, edges;
   logic         power_q, power_d, dirty_q, dirty_d, accept, snap;
   logic [2:0]   mode_q, mode_d, rep_q, rep_d;
   logic [4:0]   temp_q, temp_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic         err_q, err_d;
   logic [34:0]  frame35, rst35, data35_q;
   logic [31:0]  frame32, rst32, data32_q;

   ir_frame_build #(.FIXED35(FIXED35), .FIXED32(FIXED32)) u_frame (
      .power  (power_q),
      .mode   (mode_q),
      .temp   (temp_q),
      .data35 (frame35),
      .data32 (frame32)
   );

   // Constant-input copy provides the frame of the reset state.
   ir_frame_build #(.FIXED35(FIXED35), .FIXED32(FIXED32)) u_frame_rst (
      .power  (1'b0),
      .mode   (3'd0),
      .temp   (5'(TEMP_RST)),
      .data35 (rst35),
      .data32 (rst32)
   );

   assign edges = {key_power, key_mode, key_up, key_down} & ~keys_q;

   always_comb begin
      power_d = power_q ^ edges[3];
      mode_d  = mode_q;
      temp_d  = temp_q;
      accept  = edges[3];
      // Mode/up/down act only when the power bit is on after this cycle's toggle.
      if (power_d) begin
         if (edges[2]) begin
            accept = 1'b1;
            mode_d = (mode_q == 3'(MODE_MAX)) ? 3'd0 : mode_q + 3'd1;
         end
         if (edges[1] || edges[0]) begin
            accept = 1'b1;
            if (edges[1] && !edges[0] && temp_q != 5'(TEMP_MAX)) begin
               temp_d = temp_q + 5'd1;
            end else if (edges[0] && !edges[1] && temp_q != 5'(TEMP_MIN)) begin
               temp_d = temp_q - 5'd1;
            end
         end
      end
      dirty_d = dirty_q;
      if (snap) dirty_d = 1'b0;
      if (accept) dirty_d = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      rep_d    = rep_q;
      gap_d    = gap_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      snap     = 1'b0;
      tx_start = 1'b0;
      unique case (state_q)
         StIdle: if (dirty_q) state_d = StSnap;
         StSnap: begin
            snap    = 1'b1;
            rep_d   = REP_INIT;
            state_d = StLaunch;
         end
         StLaunch: if (!tx_busy) begin
            tx_start = 1'b1;
            tmo_d    = '0;
            state_d  = StWait;
         end
         StWait: begin
            if (tx_done) begin
               rep_d   = rep_q - 3'd1;
               gap_d   = '0;
               state_d = StGap;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               rep_d   = 3'd0;
               gap_d   = '0;
               state_d = StGap;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         StGap: begin
            if (gap_q == GAP_LAST) begin
               if (rep_q != 3'd0) state_d = StLaunch;
               else if (dirty_q)  state_d = StSnap;
               else               state_d = StIdle;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         keys_q   <= '0;
         power_q  <= 1'b0;
         mode_q   <= 3'd0;
         temp_q   <= 5'(TEMP_RST);
         dirty_q  <= 1'b0;
         state_q  <= StIdle;
         rep_q    <= 3'd0;
         gap_q    <= '0;
         tmo_q    <= '0;
         err_q    <= 1'b0;
         data35_q <= rst35;
         data32_q <= rst32;
      end else begin
         keys_q  <= {key_power, key_mode, key_up, key_down};
         power_q <= power_d;
         mode_q  <= mode_d;
         temp_q  <= temp_d;
         dirty_q <= dirty_d;
         state_q <= state_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         if (snap) begin
            data35_q <= frame35;
            data32_q <= frame32;
         end
      end
   end

   assign tx_data35  = data35_q;
   assign tx_data32  = data32_q;
   assign sched_busy = (state_q != StIdle);
   assign pwr_led    = power_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Self-checking bench for ir_cmd_scheduler: table of key presses plus hand-written
// sequences, with a frame scoreboard fed at stimulus time and checked on tx_start.
module tb_ir_cmd_scheduler;

   localparam int unsigned REPEAT = 2;
   localparam int unsigned GAP    = 50;
   localparam int unsigned TMO    = 200;
   localparam int unsigned FRAME  = 100;
   localparam logic [34:0] FIX35  = 35'b10000010000100000000010000001010010;
   localparam logic [31:0] FIX32  = 32'b00001000000001000000000000000110;
   localparam logic [3:0]  KP = 4'b1000, KM = 4'b0100, KU = 4'b0010, KD = 4'b0001;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic key_power = 1'b0, key_mode = 1'b0, key_up = 1'b0, key_down = 1'b0;
   logic tx_busy = 1'b0, tx_done = 1'b0;
   logic tx_start, sched_busy, pwr_led, err;
   logic [34:0] tx_data35;
   logic [31:0] tx_data32;

   ir_cmd_scheduler #(
      .REPEAT(REPEAT), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO), .FIXED35(FIX35), .FIXED32(FIX32)
   ) dut (
      .clk(clk), .rst(rst), .key_power(key_power), .key_mode(key_mode), .key_up(key_up),
      .key_down(key_down), .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start),
      .tx_data35(tx_data35), .tx_data32(tx_data32), .sched_busy(sched_busy),
      .pwr_led(pwr_led), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_starts = 0;
   int model_req = 0;
   int model_ack = 0;
   bit model_en = 1'b1;
   bit lenient  = 1'b0;
   int start_cyc[$];
   logic [34:0] q35[$];
   logic [31:0] q32[$];
   logic [34:0] last35 = '0;
   logic [31:0] last32 = '0;

   typedef struct {
      logic [3:0] keys;
      bit         acc;
      logic       p;
      logic [2:0] m;
      int         t;
   } vec_t;
   vec_t tbl[18];

   function automatic logic [34:0] exp35(input logic p, input logic [2:0] m, input int t);
      logic [34:0] d;
      d = FIX35;
      d[34:32] = m;
      d[31] = p;
      d[30:27] = 4'(t - 16);
      return d;
   endfunction

   function automatic logic [31:0] exp32(input logic p, input logic [2:0] m, input int t);
      logic [31:0] d;
      d = FIX32;
      d[3:0] = 4'(t - 16) + {1'b0, m} + {3'b000, p} + 4'd10;
      return d;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_frames(input logic p, input logic [2:0] m, input int t, input int n);
      for (int i = 0; i < n; i++) begin
         q35.push_back(exp35(p, m, t));
         q32.push_back(exp32(p, m, t));
      end
   endtask

   task automatic press(input logic [3:0] k);
      @(posedge clk);
      #1 {key_power, key_mode, key_up, key_down} = k;
      @(posedge clk);
      #1 {key_power, key_mode, key_up, key_down} = 4'b0000;
   endtask

   task automatic wait_idle(input string name);
      bit idle;
      idle = 1'b0;
      repeat (4) @(posedge clk);
      for (int i = 0; i < 6000 && !idle; i++) begin
         @(negedge clk);
         if (!sched_busy) idle = 1'b1;
      end
      check(name, idle, 1);
   endtask

   task automatic wait_start(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (tx_start) seen = 1'b1;
      end
      check(name, seen, 1);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: every launch pops the next expected frame.
   initial forever begin
      @(negedge clk);
      if (rst && tx_start) begin
         n_starts++;
         if (model_en) model_req++;
         start_cyc.push_back(cyc);
         last35 = tx_data35;
         last32 = tx_data32;
         if (!lenient) begin
            check("scoreboard entry for tx_start", q35.size() != 0, 1);
            if (q35.size() != 0) begin
               check("frame data35", tx_data35, q35.pop_front());
               check("frame data32", tx_data32, q32.pop_front());
            end
         end
      end
   end

   // Transmitter model: 100-cycle frame counted from the tx_start cycle.
   initial forever begin
      @(posedge clk);
      if (model_req != model_ack) begin
         model_ack++;
         #1 tx_busy = 1'b1;
         repeat (FRAME - 2) @(posedge clk);
         #1 tx_done = 1'b1;
         tx_busy = 1'b0;
         @(posedge clk);
         #1 tx_done = 1'b0;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int s0;
      int lat;
      bit got;

      tbl[0]  = '{KP,      1'b1, 1'b0, 3'd0, 26};
      tbl[1]  = '{KU,      1'b0, 1'b0, 3'd0, 26};
      tbl[2]  = '{KU,      1'b0, 1'b0, 3'd0, 26};
      tbl[3]  = '{KU,      1'b0, 1'b0, 3'd0, 26};
      tbl[4]  = '{KP,      1'b1, 1'b1, 3'd0, 26};
      tbl[5]  = '{KM,      1'b1, 1'b1, 3'd1, 26};
      tbl[6]  = '{KU,      1'b1, 1'b1, 3'd1, 27};
      tbl[7]  = '{KU | KD, 1'b1, 1'b1, 3'd1, 27};
      tbl[8]  = '{KD,      1'b1, 1'b1, 3'd1, 26};
      tbl[9]  = '{KM,      1'b1, 1'b1, 3'd2, 26};
      tbl[10] = '{KM,      1'b1, 1'b1, 3'd3, 26};
      tbl[11] = '{KM,      1'b1, 1'b1, 3'd4, 26};
      tbl[12] = '{KM,      1'b1, 1'b1, 3'd0, 26};
      tbl[13] = '{KP,      1'b1, 1'b0, 3'd0, 26};
      tbl[14] = '{KM,      1'b0, 1'b0, 3'd0, 26};
      tbl[15] = '{KP | KU, 1'b1, 1'b1, 3'd0, 27};
      tbl[16] = '{KP | KM, 1'b1, 1'b0, 3'd0, 27};
      tbl[17] = '{KP,      1'b1, 1'b1, 3'd0, 27};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset tx_start", tx_start, 0);
      check("reset sched_busy", sched_busy, 0);
      check("reset err", err, 0);
      check("reset pwr_led", pwr_led, 0);
      check("reset data35", tx_data35, exp35(1'b0, 3'd0, 26));
      check("reset data32", tx_data32, exp32(1'b0, 3'd0, 26));
      @(negedge clk) rst = 1'b1;

      // Power on: launch latency and repeat spacing
      push_frames(1'b1, 3'd0, 26, REPEAT);
      s  = n_starts;
      s0 = start_cyc.size();
      @(posedge clk);
      #1 key_power = 1'b1;
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         lat++;
         #1 key_power = 1'b0;
         @(negedge clk);
         if (tx_start) got = 1'b1;
      end
      check("key-to-tx_start latency", lat, 3);
      check("power-on pwr_led", pwr_led, 1);
      check("power-on data35 power bit", tx_data35[31], 1);
      check("power-on temp_code", tx_data35[30:27], 10);
      check("power-on chk", tx_data32[3:0], 5);
      wait_idle("power-on frames complete");
      check("power-on start count", n_starts - s, REPEAT);
      check("power-on repeat spacing",
            (start_cyc.size() >= s0 + 2) ? start_cyc[s0+1] - start_cyc[s0] : -1, 150);

      // Table of single-cycle key presses
      for (int i = 0; i < 18; i++) begin
         s = n_starts;
         if (tbl[i].acc) push_frames(tbl[i].p, tbl[i].m, tbl[i].t, REPEAT);
         press(tbl[i].keys);
         if (tbl[i].acc) wait_idle($sformatf("row %0d idle", i));
         else repeat (6) @(posedge clk);
         @(negedge clk);
         check($sformatf("row %0d start count", i), n_starts - s, tbl[i].acc ? REPEAT : 0);
         check($sformatf("row %0d pwr_led", i), pwr_led, tbl[i].p);
         check($sformatf("row %0d sched_busy", i), sched_busy, 0);
         check($sformatf("row %0d scoreboard drained", i), q35.size(), 0);
      end

      // Six up presses from 27: first snapshot 28, second (after repeats) saturated 30
      s = n_starts;
      push_frames(1'b1, 3'd0, 28, REPEAT);
      push_frames(1'b1, 3'd0, 30, REPEAT);
      for (int i = 0; i < 6; i++) press(KU);
      wait_idle("up burst idle");
      check("up burst start count", n_starts - s, 2 * REPEAT);
      check("up burst final chk", tx_data32[3:0], 9);
      check("up burst scoreboard drained", q35.size(), 0);

      // Sixteen down presses saturate at 16; only the final frame is checked
      lenient = 1'b1;
      for (int i = 0; i < 16; i++) press(KD);
      wait_idle("down burst idle");
      lenient = 1'b0;
      check("down burst last data35", last35, exp35(1'b1, 3'd0, 16));
      check("down burst last data32", last32, exp32(1'b1, 3'd0, 16));

      // Transmitter never answers: timeout sets err and aborts the repeat
      model_en = 1'b0;
      s = n_starts;
      push_frames(1'b1, 3'd0, 17, 1);
      press(KU);
      wait_start("timeout launch");
      repeat (TMO) @(posedge clk);
      @(negedge clk);
      check("err before timeout", err, 0);
      @(posedge clk);
      @(negedge clk);
      check("err at timeout", err, 1);
      wait_idle("timeout idle");
      check("timeout start count", n_starts - s, 1);
      check("timeout scoreboard drained", q35.size(), 0);
      model_en = 1'b1;

      // tx_done while idle is ignored
      @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("stray tx_done sched_busy", sched_busy, 0);
      check("err sticky", err, 1);

      // Reset in WAIT
      push_frames(1'b1, 3'd0, 18, REPEAT);
      press(KU);
      wait_start("pre-reset launch");
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid-frame reset tx_start", tx_start, 0);
      check("mid-frame reset sched_busy", sched_busy, 0);
      check("mid-frame reset err", err, 0);
      check("mid-frame reset pwr_led", pwr_led, 0);
      check("mid-frame reset data35", tx_data35, exp35(1'b0, 3'd0, 26));
      check("mid-frame reset data32", tx_data32, exp32(1'b0, 3'd0, 26));
      check("aborted repeats pending", q35.size(), REPEAT - 1);
      q35.delete();
      q32.delete();
      @(negedge clk) rst = 1'b1;
      s = n_starts;
      push_frames(1'b1, 3'd0, 26, REPEAT);
      press(KP);
      wait_idle("post-reset idle");
      check("post-reset start count", n_starts - s, REPEAT);
      check("post-reset pwr_led", pwr_led, 1);
      check("final scoreboard drained", q35.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
